// File: rtl/fringe_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : fringe_pattern_gen
// Function : Four-step phase-shifted cosine fringe generator on AXI4-Stream.
//            Optional macro FPG_VERTICAL_EN adds cfg_vertical (row-indexed stripes).
// Revision : 1.0  initial release
// ============================================================================
module fringe_pattern_gen #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int FRAME_W         = 1024,
  parameter int FRAME_H         = 768,
  parameter int PERIOD          = 32
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         start,
`ifdef FPG_VERTICAL_EN
  input  logic                         cfg_vertical,
`endif
  output logic                         busy,
  output logic                         done,
  output logic [8*PIXELS_PER_BEAT-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast
);

  localparam int C_BEATS = FRAME_W / PIXELS_PER_BEAT;
  localparam int C_BX_W  = (C_BEATS > 1) ? $clog2(C_BEATS) : 1;
  localparam int C_ROW_W = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam int C_INC   = 256 / PERIOD;
  localparam logic [C_BX_W-1:0]  C_BX_LAST  = C_BX_W'(C_BEATS - 1);
  localparam logic [C_ROW_W-1:0] C_ROW_LAST = C_ROW_W'(FRAME_H - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Small epsilon keeps exact .0 results (e.g. index 192) from flooring one low.
  function automatic logic [7:0] lut_entry(input int n);
    real v;
    v = $floor(127.5 + 127.5 * $cos(2.0 * 3.14159265358979323846 * real'(n) / 256.0)
               + 0.5 + 1.0e-9);
    if (v < 0.0)   v = 0.0;
    if (v > 255.0) v = 255.0;
    return 8'($rtoi(v));
  endfunction

  function automatic logic [7:0] pix_idx(input int unsigned pos, input logic [1:0] k);
    return 8'(pos * C_INC) + {k, 6'b0};
  endfunction

  state_t               r_state;
  logic [C_BX_W-1:0]    r_bx;
  logic [C_ROW_W-1:0]   r_row;
  logic [1:0]           r_step;

  logic [7:0]           w_lut [256];
  logic                 w_vert;
  logic                 w_hs;
  logic                 w_last_bx;
  logic                 w_last_row;
  logic                 w_final;
  logic [C_BX_W-1:0]    w_nx_bx;
  logic [C_ROW_W-1:0]   w_nx_row;
  logic [1:0]           w_nx_step;
  logic                 w_nx_tlast;
  logic [8*PIXELS_PER_BEAT-1:0] w_nxt_data;

  for (genvar n = 0; n < 256; n++) begin : g_lut
    assign w_lut[n] = lut_entry(n);
  end

`ifdef FPG_VERTICAL_EN
  logic r_vert;
  // The first beat is built while still idle, so it must see the live input.
  assign w_vert = (r_state == S_IDLE) ? cfg_vertical : r_vert;
`else
  assign w_vert = 1'b0;
`endif

  assign w_hs       = m_axis_tvalid & m_axis_tready;
  assign w_last_bx  = (r_bx == C_BX_LAST);
  assign w_last_row = (r_row == C_ROW_LAST);
  assign w_final    = w_last_bx & w_last_row & (r_step == 2'd3);

  // Coordinates of the beat to be loaded next into the output register.
  always_comb begin
    w_nx_bx   = '0;
    w_nx_row  = '0;
    w_nx_step = 2'd0;
    if (r_state != S_IDLE) begin
      w_nx_bx   = w_last_bx ? '0 : r_bx + 1'b1;
      w_nx_row  = w_last_bx ? (w_last_row ? '0 : r_row + 1'b1) : r_row;
      w_nx_step = (w_last_bx & w_last_row) ? r_step + 2'd1 : r_step;
    end
  end

  assign w_nx_tlast = (w_nx_bx == C_BX_LAST) && (w_nx_row == C_ROW_LAST);

  for (genvar p = 0; p < PIXELS_PER_BEAT; p++) begin : g_pix
    logic [7:0]  w_idx;
    int unsigned w_pos;
    assign w_pos = w_vert ? 32'(w_nx_row)
                          : 32'(w_nx_bx) * PIXELS_PER_BEAT + p;
    assign w_idx = pix_idx(w_pos, w_nx_step);
    assign w_nxt_data[8*p +: 8] = w_lut[w_idx];
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state       <= S_IDLE;
      r_bx          <= '0;
      r_row         <= '0;
      r_step        <= 2'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
`ifdef FPG_VERTICAL_EN
      r_vert        <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_state       <= S_RUN;
            r_bx          <= '0;
            r_row         <= '0;
            r_step        <= 2'd0;
            busy          <= 1'b1;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= w_nxt_data;
            m_axis_tlast  <= w_nx_tlast;
`ifdef FPG_VERTICAL_EN
            r_vert        <= cfg_vertical;
`endif
          end
        end
        S_RUN: begin
          if (w_hs) begin
            if (w_final) begin
              r_state       <= S_DONE;
              busy          <= 1'b0;
              done          <= 1'b1;
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              m_axis_tdata  <= '0;
            end else begin
              r_bx          <= w_nx_bx;
              r_row         <= w_nx_row;
              r_step        <= w_nx_step;
              m_axis_tdata  <= w_nxt_data;
              m_axis_tlast  <= w_nx_tlast;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fringe_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_fringe_pattern_gen
// Function : Directed self-checking bench for fringe_pattern_gen (64x2 frame, period 16).
// Revision : 1.0  initial release
// ============================================================================
module tb_fringe_pattern_gen;

  localparam int PPB    = 16;
  localparam int FW     = 64;
  localparam int FH     = 2;
  localparam int PER    = 16;
  localparam int NBEATS = 32;
  localparam int BUDGET = 400;

  logic           aclk = 1'b0;
  logic           areset;
  logic           start;
  logic           cfg_vertical;
  logic           busy;
  logic           done;
  logic [127:0]   tdata;
  logic           tvalid;
  logic           tready;
  logic           tlast;

  int n_cmp  = 0;
  int n_fail = 0;

  fringe_pattern_gen #(
    .PIXELS_PER_BEAT(PPB),
    .FRAME_W        (FW),
    .FRAME_H        (FH),
    .PERIOD         (PER)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .start        (start),
`ifdef FPG_VERTICAL_EN
    .cfg_vertical (cfg_vertical),
`endif
    .busy         (busy),
    .done         (done),
    .m_axis_tdata (tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast (tlast)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_lut(input int n);
    real v;
    v = $floor(127.5 + 127.5 * $cos(2.0 * 3.14159265358979323846 * real'(n) / 256.0)
               + 0.5 + 1.0e-9);
    if (v < 0.0)   v = 0.0;
    if (v > 255.0) v = 255.0;
    return 8'($rtoi(v));
  endfunction

  // Beat n of the sequence: 4 beats per row, 2 rows per frame, 4 frames.
  function automatic logic [127:0] exp_beat(input int n, input bit vert);
    logic [127:0] r;
    int step, row, bx, pos;
    step = n / 8;
    row  = (n / 4) % 2;
    bx   = n % 4;
    r    = '0;
    for (int p = 0; p < PPB; p++) begin
      pos = vert ? row : bx * PPB + p;
      r[8*p +: 8] = ref_lut((pos * (256 / PER) + 64 * step) % 256);
    end
    return r;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},   busy,   0);
    chk({tag, "_done"},   done,   0);
    chk({tag, "_tvalid"}, tvalid, 0);
    chk({tag, "_tlast"},  tlast,  0);
    chk({tag, "_tdata"},  tdata,  0);
  endtask

  // Pulses start, consumes the sequence and checks framing/done timing.
  // abort_at >= 0 returns at that beat count without waiting for the end.
  task automatic run_seq(input bit bp, input bit poke, input int abort_at, input bit vert);
    int           n;
    bit           stalled;
    logic [127:0] held_d;
    logic         held_l;
    n       = 0;
    stalled = 0;
    held_d  = '0;
    held_l  = 1'b0;
    cfg_vertical = vert;
    start = 1'b1;
    @(posedge aclk);
    #1;
    start        = 1'b0;
    cfg_vertical = 1'b0;
    tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge aclk);
      if (abort_at >= 0 && n == abort_at) return;
      if (!bp) chk("gapless_tvalid", tvalid, 1);
      chk("busy_in_seq", busy, 1);
      chk("no_early_done", done, 0);
      if (stalled) begin
        chk("stall_tdata", tdata, held_d);
        chk("stall_tlast", tlast, held_l);
      end
      if (tvalid && tready) begin
        chk($sformatf("beat%0d_data", n), tdata, exp_beat(n, vert));
        chk($sformatf("beat%0d_tlast", n), tlast, ((n % 8) == 7));
        if (!vert) begin
          if (n == 0) begin
            chk("s0_px0",  tdata[7:0],     8'd255);
            chk("s0_px4",  tdata[39:32],   8'd128);
            chk("s0_px8",  tdata[71:64],   8'd0);
            chk("s0_px12", tdata[103:96],  8'd128);
          end
          if (n == 8)  chk("s1_px0", tdata[7:0], 8'd128);
          if (n == 16) chk("s2_px0", tdata[7:0], 8'd0);
          if (n == 24) chk("s3_px0", tdata[7:0], 8'd128);
        end else if (n < 8) begin
          chk($sformatf("vert_beat%0d", n), tdata,
              (n < 4) ? {16{8'd255}} : {16{ref_lut(16)}});
        end
        n++;
        stalled = 0;
      end else if (tvalid) begin
        stalled = 1;
        held_d  = tdata;
        held_l  = tlast;
      end
      if (n == NBEATS) break;
      @(posedge aclk);
      #1;
      tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      start  = poke && (n == 5 || n == NBEATS - 1);
    end
    chk("beat_count", n, NBEATS);
    @(posedge aclk);
    #1;
    start  = 1'b0;
    tready = 1'b1;
    @(negedge aclk);
    chk("done_pulse", done, 1);
    chk("busy_after", busy, 0);
    chk("tvalid_after", tvalid, 0);
    @(posedge aclk);
    #1;
    @(negedge aclk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    areset       = 1'b1;
    start        = 1'b0;
    tready       = 1'b0;
    cfg_vertical = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk_reset_vals("reset");
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);

    run_seq(1'b0, 1'b0, -1, 1'b0);
    run_seq(1'b1, 1'b0, -1, 1'b0);
    run_seq(1'b0, 1'b1, -1, 1'b0);
    run_seq(1'b0, 1'b0, -1, 1'b0);

    run_seq(1'b0, 1'b0, 12, 1'b0);
    #1;
    areset = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    repeat (3) begin
      @(negedge aclk);
      chk("reset_no_done", done, 0);
    end
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk_reset_vals("post_reset");
    run_seq(1'b0, 1'b0, -1, 1'b0);

`ifdef FPG_VERTICAL_EN
    run_seq(1'b0, 1'b0, -1, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
